// File: rtl/bcd_display_scheduler_if.sv
// ---------------------------------------------------------------------------
// bcd_display_scheduler_if
//   Bundles the data and status signals of bcd_display_scheduler.
//   master : producer side (switch/counter logic). Drives BCD_IN, LOAD, AUTO
//            and observes HEX_OUT, ERR, BUSY, DONE.
//   slave  : the scheduler itself, the mirror image of master.
//   Signals
//     BCD_IN   4*NDIG  packed nibbles, digit i = BCD_IN[4i+3:4i]
//     LOAD     1       request one scan/commit pass
//     AUTO     1       restart a pass right after every commit
//     HEX_OUT  7*NDIG  active-low segments, digit i = HEX_OUT[7i+6:7i]
//     ERR      NDIG    committed nibble i was above 9
//     BUSY     1       a pass is in progress
//     DONE     1       one-cycle pulse after the commit
// ---------------------------------------------------------------------------
interface bcd_display_scheduler_if #(
  parameter int NDIG = 4
);
  logic [4*NDIG-1:0] BCD_IN;
  logic              LOAD;
  logic              AUTO;
  logic [7*NDIG-1:0] HEX_OUT;
  logic [NDIG-1:0]   ERR;
  logic              BUSY;
  logic              DONE;

  modport master (
    output BCD_IN,
    output LOAD,
    output AUTO,
    input  HEX_OUT,
    input  ERR,
    input  BUSY,
    input  DONE
  );

  modport slave (
    input  BCD_IN,
    input  LOAD,
    input  AUTO,
    output HEX_OUT,
    output ERR,
    output BUSY,
    output DONE
  );
endinterface

// File: rtl/bcd_display_scheduler.sv
// ---------------------------------------------------------------------------
// bcd_display_scheduler
//   Shares a single BCD-to-7-segment decoder (with a >9 range check) across
//   NDIG display digits. A pass snapshots the packed BCD word, walks the
//   digits through the decoder one slot at a time (DIV cycles per slot) into
//   a staging buffer, then commits every digit to the outputs on one edge so
//   the display never shows a half-updated number.
//
//   Ports
//     CLOCK_50  in   system clock, rising edge
//     RESET     in   asynchronous, active-high reset
//     bus       slave side of bcd_display_scheduler_if (BCD_IN, LOAD, AUTO
//               in; HEX_OUT, ERR, BUSY, DONE out, all outputs registered)
//
//   Timing: a start taken at edge k commits on edge k+NDIG*DIV+1, and DONE
//   is high for the single cycle that follows that edge.
// ---------------------------------------------------------------------------
module bcd_display_scheduler #(
  parameter int NDIG = 4,
  parameter int DIV  = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET,
  bcd_display_scheduler_if.slave bus
);

  // Counter widths, never narrower than one bit.
  localparam int SW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [SW-1:0] SLOT_LAST = SW'(NDIG - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [SW-1:0] SLOT_ONE  = SW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low segment pattern for one nibble; 10..15 show a dash (g only).
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b0111111;
    endcase
    return seg;
  endfunction

  // Range check paired with the decoder: nibble is not a valid BCD digit.
  function automatic logic nib_out_of_range(input logic [3:0] nib);
    return (nib > 4'd9);
  endfunction

  // State and datapath registers.
  logic [1:0]            state_r;
  logic [NDIG-1:0][3:0]  shadow_r;
  logic [SW-1:0]         slot_r;
  logic [CW-1:0]         cnt_r;
  logic                  pending_r;
  logic [NDIG-1:0][6:0]  staging_r;
  logic [NDIG-1:0]       errstage_r;
  logic [NDIG-1:0][6:0]  hex_r;
  logic [NDIG-1:0]       err_r;
  logic                  busy_r;
  logic                  done_r;

  // Combinational control.
  logic [1:0]            state_nx_s;
  logic                  start_s;
  logic                  slot_end_s;
  logic                  last_slot_s;
  logic                  commit_s;
  logic                  pend_set_s;
  logic [3:0]            nibble_s;
  logic [6:0]            seg_s;
  logic                  range_err_s;

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    state_nx_s  = state_r;
    start_s     = 1'b0;
    slot_end_s  = 1'b0;
    last_slot_s = 1'b0;
    commit_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.LOAD || bus.AUTO || pending_r) begin
          start_s    = 1'b1;
          state_nx_s = ST_SCAN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (cnt_r == CNT_LAST) begin
          slot_end_s = 1'b1;
          if (slot_r == SLOT_LAST) begin
            last_slot_s = 1'b1;
            state_nx_s  = ST_UPDATE;
          end else begin
            state_nx_s  = ST_SCAN;
          end
        end else begin
          state_nx_s = ST_SCAN;
        end
      end
      ST_UPDATE: begin
        commit_s   = 1'b1;
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // A LOAD seen while a pass is running (including the commit edge) is
  // remembered as one extra pass; repeats simply re-set the same flag.
  always_comb begin
    if ((state_r == ST_SCAN) || (state_r == ST_UPDATE)) begin
      pend_set_s = bus.LOAD;
    end else begin
      pend_set_s = 1'b0;
    end
  end

  // Shared decoder: fed from the snapshot digit selected by the slot counter.
  always_comb begin
    nibble_s    = shadow_r[slot_r];
    seg_s       = seg_decode(nibble_s);
    range_err_s = nib_out_of_range(nibble_s);
  end

  // FSM state register.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Slot and divider counters; both stop at their last value and restart at 0.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      slot_r <= {SW{1'b0}};
      cnt_r  <= {CW{1'b0}};
    end else if (start_s) begin
      slot_r <= {SW{1'b0}};
      cnt_r  <= {CW{1'b0}};
    end else if (slot_end_s) begin
      cnt_r <= {CW{1'b0}};
      if (last_slot_s) begin
        slot_r <= {SW{1'b0}};
      end else begin
        slot_r <= slot_r + SLOT_ONE;
      end
    end else if (state_r == ST_SCAN) begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  // Input snapshot: taken only when a pass starts, so BCD_IN may move freely
  // while the digits are being scanned.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      shadow_r <= '0;
    end else if (start_s) begin
      shadow_r <= bus.BCD_IN;
    end
  end

  // One-deep request memory; consumed by the start it causes.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      pending_r <= 1'b0;
    end else if (start_s) begin
      pending_r <= 1'b0;
    end else if (pend_set_s) begin
      pending_r <= 1'b1;
    end
  end

  // Staging buffer written one digit per slot; reset discards a partial scan.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      staging_r  <= {NDIG{SEG_BLANK}};
      errstage_r <= {NDIG{1'b0}};
    end else if (slot_end_s) begin
      staging_r[slot_r]  <= seg_s;
      errstage_r[slot_r] <= range_err_s;
    end
  end

  // Display outputs change only on the commit edge, all digits together.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      hex_r <= {NDIG{SEG_BLANK}};
      err_r <= {NDIG{1'b0}};
    end else if (commit_s) begin
      hex_r <= staging_r;
      err_r <= errstage_r;
    end
  end

  // Status flags: BUSY follows the registered next state so it drops on the
  // edge that re-enters IDLE; DONE is a single-cycle strobe after commit.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_nx_s != ST_IDLE);
      done_r <= commit_s;
    end
  end

  assign bus.HEX_OUT = hex_r;
  assign bus.ERR     = err_r;
  assign bus.BUSY    = busy_r;
  assign bus.DONE    = done_r;

endmodule
